// File: rtl/reg_check_sequencer.sv
// Register-check sequencer: holds the core in reset, lets it run, then walks an expected-value
// table (EXP_TABLE, entry k = {addr, value} at bits k*(REG_ADDR_WIDTH+DATA_WIDTH)) over a debug read port.
// Optional build macro REGCHK_HALT_EN: RUN ends on halt_i, with timeout reporting.
module reg_check_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_CHECKS     = 8,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter int unsigned RUN_CYCLES     = 100,
    parameter logic [NUM_CHECKS*(REG_ADDR_WIDTH+DATA_WIDTH)-1:0] EXP_TABLE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      halt_i,
    output logic                      core_rst_n_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0]     rd_data_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic                      timeout_o,
    output logic [8:0]                err_cnt_o,
    output logic [7:0]                fail_idx_o
);

    localparam int unsigned ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_MAX = (RUN_CYCLES > RESET_CYCLES) ? RUN_CYCLES : RESET_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned ERR_W   = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_CORE_RST, S_RUN, S_RD, S_CMP, S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [ERR_W-1:0]          err_q, err_d;
    logic [IDX_W-1:0]          fail_q, fail_d;
    logic                      timeout_q, timeout_d;
    logic                      pass_q, pass_d;
    logic                      core_rst_n_q, core_rst_n_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    // Table padded to the full 8-bit index range so idx_q addresses it directly
    logic [ENTRY_W-1:0] table_w [256];
    for (genvar g = 0; g < 256; g++) begin : g_table
        if (g < NUM_CHECKS) begin : g_used
            assign table_w[g] = EXP_TABLE[g*ENTRY_W +: ENTRY_W];
        end else begin : g_pad
            assign table_w[g] = '0;
        end
    end

    logic [ENTRY_W-1:0]        cur_entry;
    logic [REG_ADDR_WIDTH-1:0] cur_addr;
    logic [REG_ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0]     cur_val;

    assign cur_entry = table_w[idx_q];
    assign cur_addr  = cur_entry[ENTRY_W-1 -: REG_ADDR_WIDTH];
    assign cur_val   = cur_entry[DATA_WIDTH-1:0];
    assign nxt_addr  = table_w[idx_q + IDX_W'(1)][ENTRY_W-1 -: REG_ADDR_WIDTH];

`ifndef REGCHK_HALT_EN
    logic unused_halt;
    assign unused_halt = halt_i;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        rd_addr_d = rd_addr_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_CORE_RST;
                    cnt_d     = '0;
                    idx_d     = '0;
                    err_d     = '0;
                    fail_d    = 8'hFF;
                    timeout_d = 1'b0;
                end
            end
            S_CORE_RST: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
`ifdef REGCHK_HALT_EN
                if (halt_i) begin
                    state_d   = S_RD;
                    rd_addr_d = cur_addr;
                end else if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d   = S_RD;
                    rd_addr_d = cur_addr;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d   = S_RD;
                    rd_addr_d = cur_addr;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                // Case inequality so X/Z read data counts as a mismatch in simulation
                if (rd_data_i !== cur_val) begin
                    if (err_q != ERR_W'(511)) err_d = err_q + ERR_W'(1);
                    if (fail_q == 8'hFF)      fail_d = idx_q;
                end
                if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    state_d   = S_RD;
                    rd_addr_d = nxt_addr;
                end
            end
            default: state_d = S_IDLE;
        endcase

        core_rst_n_d = (state_d != S_IDLE) && (state_d != S_CORE_RST);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
        pass_d       = done_d && (err_d == '0) && !timeout_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            err_q        <= '0;
            fail_q       <= 8'hFF;
            timeout_q    <= 1'b0;
            pass_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            pass_q       <= pass_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign core_rst_n_o = core_rst_n_q;
    assign rd_addr_o    = rd_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign err_cnt_o    = err_q;
    assign fail_idx_o   = fail_q;

endmodule
